// File: rtl/mem_copy_engine_pkg.sv
// ============================================================================
// Module      : mem_copy_engine_pkg
// Description : Shared state encoding and constants for the memory copy engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_copy_engine_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int   WORD_BYTES   = 4;
    localparam logic MEM_INACTIVE = 1'b1;

endpackage

`default_nettype wire

// File: rtl/mem_copy_engine.sv
// ============================================================================
// Module      : mem_copy_engine
// Description : Word-by-word forward memory copy over a shared single-port bus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_copy_engine
    import mem_copy_engine_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [CNT_W-1:0] word_count,
    output logic             busy,
    output logic             done,
    output logic [31:0]      DAddr,
    output logic [31:0]      MemDataIn,
    input  logic [31:0]      MemDataOut,
    output logic             RD,
    output logic             WR
);

    state_t           state;
    state_t           state_nxt;
    logic [31:0]      src_ptr;
    logic [31:0]      dst_ptr;
    logic [31:0]      buffer;
    logic [CNT_W-1:0] remaining;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Bus outputs decode from state and registers only, so start never reaches RD/WR.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        RD        = MEM_INACTIVE;
        WR        = MEM_INACTIVE;
        DAddr     = 32'h0;
        MemDataIn = 32'h0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (word_count == '0) ? DONE : READ;
                end
            end
            READ: begin
                busy      = 1'b1;
                RD        = 1'b0;
                DAddr     = src_ptr;
                state_nxt = WRITE;
            end
            WRITE: begin
                busy      = 1'b1;
                WR        = 1'b0;
                DAddr     = dst_ptr;
                MemDataIn = buffer;
                state_nxt = (remaining == CNT_W'(1)) ? DONE : READ;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            src_ptr   <= 32'h0;
            dst_ptr   <= 32'h0;
            buffer    <= 32'h0;
            remaining <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && (word_count != '0)) begin
                        src_ptr   <= {src_addr[31:2], 2'b00};
                        dst_ptr   <= {dst_addr[31:2], 2'b00};
                        remaining <= word_count;
                    end
                end
                READ: begin
                    buffer <= MemDataOut;
                end
                WRITE: begin
                    src_ptr   <= src_ptr + 32'(WORD_BYTES);
                    dst_ptr   <= dst_ptr + 32'(WORD_BYTES);
                    remaining <= remaining - CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire
